// File: rtl/bist_pattern_gen_if.sv
// Pattern/response handshake between the BIST generator and the CUT wrapper.
interface bist_pattern_gen_if #(
  parameter int WIDTH = 2
);
  logic [WIDTH-1:0] pat_out;
  logic             pat_valid;
  logic             pat_ready;
  logic             resp_in;

  modport master (output pat_out, pat_valid, input pat_ready, resp_in);
  modport slave  (input pat_out, pat_valid, output pat_ready, resp_in);
endinterface

// File: rtl/bist_pattern_gen.sv
// BIST stimulus generator: exhaustive or maximal-length LFSR patterns applied
// over a valid/ready handshake, CUT responses compacted into a 16-bit MISR.
module bist_pattern_gen #(
  parameter int WIDTH = 2,
  parameter int SEED  = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      mode,
  input  logic [15:0]               num_pats,
  bist_pattern_gen_if.master        bus,
  output logic [15:0]               signature,
  output logic [15:0]               pat_count,
  output logic                      busy,
  output logic                      done
);
  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  localparam logic [WIDTH-1:0] SEED_W    = SEED[WIDTH-1:0];
  // An all-zero LFSR state is a lock-up state, so a zero seed becomes 1.
  localparam logic [WIDTH-1:0] LFSR_INIT = (SEED_W == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : SEED_W;
  localparam logic [15:0]      EXH_FULL  = 16'(2 ** WIDTH);
  localparam logic [15:0]      LFSR_FULL = EXH_FULL - 16'd1;

  // Feedback bit for a maximal-length Fibonacci LFSR of the configured width.
  function automatic logic lfsr_fb(input logic [WIDTH-1:0] p);
    logic [7:0] q;
    q = '0;
    q[WIDTH-1:0] = p;
    case (WIDTH)
      2:       return q[1] ^ q[0];
      3:       return q[2] ^ q[1];
      4:       return q[3] ^ q[2];
      5:       return q[4] ^ q[2];
      6:       return q[5] ^ q[4];
      7:       return q[6] ^ q[5];
      default: return q[7] ^ q[5] ^ q[4] ^ q[3];
    endcase
  endfunction

  state_t           state, state_nxt;
  logic [WIDTH-1:0] pattern;
  logic             mode_lat;
  logic [15:0]      target;
  logic             xfer;
  logic             misr_fb;

  assign xfer    = (state == RUN) && bus.pat_ready;
  assign misr_fb = signature[15] ^ signature[13] ^ signature[12] ^ signature[10];
  assign bus.pat_out = pattern;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and status outputs; run ends on the transfer that reaches target.
  always_comb begin
    state_nxt     = state;
    bus.pat_valid = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        bus.pat_valid = 1'b1;
        busy          = 1'b1;
        if (xfer && (16'(pat_count + 16'd1) == target)) state_nxt = FINISH;
      end
      FINISH: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Run setup on start, then pattern advance, count and MISR on each transfer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pattern   <= '0;
      signature <= '0;
      pat_count <= '0;
      mode_lat  <= 1'b0;
      target    <= '0;
    end else if (state == IDLE && start) begin
      mode_lat  <= mode;
      target    <= (num_pats != 16'd0) ? num_pats : (mode ? LFSR_FULL : EXH_FULL);
      pattern   <= mode ? LFSR_INIT : '0;
      signature <= '0;
      pat_count <= '0;
    end else if (xfer) begin
      pat_count <= pat_count + 16'd1;
      signature <= {signature[14:0], misr_fb ^ bus.resp_in};
      pattern   <= mode_lat ? {pattern[WIDTH-2:0], lfsr_fb(pattern)} : pattern + 1'b1;
    end
  end
endmodule

// File: doc/bist_pattern_gen.md
Name: bist_pattern_gen

Overview:
- Upstream stimulus stage for single-gate and small-netlist fault-simulation benches.
- Generates test patterns for the circuit under test (CUT) in one of two modes: exhaustive count or maximal-length LFSR.
- Applies each pattern through a valid/ready handshake and samples the CUT's 1-bit response on every accepted transfer.
- Compacts the responses into a 16-bit MISR signature, so a good-circuit run can be compared against faulty runs.

Parameters:
- WIDTH, 2: pattern width (CUT input count). Legal range 2..8.
- SEED, 1: initial LFSR state (WIDTH bits). A zero seed is forced to 1 in LFSR mode.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; synchronous, active-low.
- start  input  1  one-cycle request to begin a run; sampled only in IDLE.
- mode  input  1  0 = exhaustive counter, 1 = LFSR; latched at start.
- num_pats  input  16  number of patterns to apply; latched at start. 0 = full space (2^WIDTH exhaustive, 2^WIDTH-1 LFSR).
- pat_out  output  WIDTH  current pattern to the CUT.
- pat_valid  output  1  pat_out holds a valid pattern.
- pat_ready  input  1  consumer accepts pat_out this cycle.
- resp_in  input  1  CUT response to pat_out; sampled when pat_valid && pat_ready.
- signature  output  16  MISR value.
- pat_count  output  16  number of accepted transfers in the current or last run.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse after the last accepted transfer.

Behaviour:
- Reset (rst_n=0 at a clock edge) forces the following, from any state including mid-run:
  - state=IDLE;
  - pat_out=0, pat_valid=0, busy=0, done=0;
  - signature=16'h0000, pat_count=0.
- States are IDLE, RUN, FINISH.
- IDLE:
  - start=1 latches mode and num_pats.
  - It loads pat_out with 0 (exhaustive) or SEED (LFSR; 1 if SEED==0).
  - It clears signature and pat_count.
  - Next state is RUN. pat_valid=1 and busy=1 from the first RUN cycle, i.e. 1-cycle latency from start.
- RUN, transfer rule: a transfer occurs when pat_valid && pat_ready.
- RUN, on a transfer:
  - pat_count increments.
  - MISR updates: fb = sig[15]^sig[13]^sig[12]^sig[10]; sig_next = {sig[14:0], fb ^ resp_in}.
  - pat_out advances.
    - Exhaustive: pat_out+1, wrapping modulo 2^WIDTH.
    - LFSR: Fibonacci shift-left, pat_out <= {pat_out[WIDTH-2:0], x}, where x is the XOR of the tap bits for WIDTH:
      - WIDTH 2: taps 1,0
      - WIDTH 3: taps 2,1
      - WIDTH 4: taps 3,2
      - WIDTH 5: taps 4,2
      - WIDTH 6: taps 5,4
      - WIDTH 7: taps 6,5
      - WIDTH 8: taps 7,5,4,3
- RUN, backpressure: with pat_ready=0, pat_out, signature and pat_count hold; pat_valid stays 1.
- Run termination:
  - When the accepted transfer makes pat_count equal the target (num_pats, or the full-space value if num_pats==0), next state is FINISH.
  - The final pat_out advance is not presented: pat_valid=0 in FINISH.
- num_pats larger than the pattern space: patterns repeat cyclically until the count is reached.
- FINISH lasts one cycle: done=1, busy=0, pat_valid=0, then state returns to IDLE.
- signature and pat_count hold until the next start or reset.
- start while in RUN or FINISH is ignored (no restart, no latch).
- Changes to mode and num_pats during a run have no effect.
- A start in the same cycle as rst_n=0: reset wins.

Test Plan:
- WIDTH=2, mode=0, num_pats=0, pat_ready=1, resp_in = NAND of pat_out -> pat_out 00,01,10,11 on consecutive RUN cycles. Then done pulses one cycle later, pat_count=4, signature=16'h000E.
- WIDTH=2, mode=1, SEED=1, num_pats=0 -> pat_out 01,11,10; pat_count=3; done pulses once; busy low afterwards.
- WIDTH=2, mode=0, num_pats=6 -> pat_out 00,01,10,11,00,01 (wrap-around); pat_count=6.
- Same setup as the first scenario, with pat_ready low for 3 cycles while pat_out=01 -> pat_out, signature and pat_count stable during the stall. Final signature is still 16'h000E.
- rst_n=0 for one cycle after 2 transfers -> next cycle pat_valid=0, busy=0, signature=0, pat_count=0, state IDLE. No done pulse.
- start pulsed again during RUN -> ignored: sequence and count are identical to the first scenario, with exactly one done pulse.
